beh_rand_delay_checker: RTL and testbench

Synthesizable-style, clock-based observer for the far end of a beh_rand_delay instance. It watches the delay element's bus_in and bus_out in one clock domain and records every input transition with a timestamp. It matches each output transition back to a recorded input value and flags ordering, timing, loss and overflow violations against the delay element's MIN/MAX/FIXED settings. It sits in unit benches and SoC-level harnesses beside each delay instance, replacing end-of-test edge-count comparison with per-transition checking.

---
 rtl/beh_rand_delay_checker_pkg.sv | 13 +
 rtl/beh_rand_delay_checker_store.sv | 100 ++++++++++
 rtl/beh_rand_delay_checker.sv | 98 +++++++++
 tb/tb_beh_rand_delay_checker.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/beh_rand_delay_checker_pkg.sv
// Shared types and helpers for the beh_rand_delay transition checker.
package beh_rand_delay_checker_pkg;

  localparam int unsigned TS_W = 16;

  typedef logic [TS_W-1:0] ts_t;

  // Wrap-safe age of a stored timestamp relative to the current one.
  function automatic ts_t age(input ts_t ts_now, input ts_t ts_entry);
    return ts_t'(ts_now - ts_entry);
  endfunction

endpackage

// File: rtl/beh_rand_delay_checker_store.sv
// Circular pending-transition store: push, oldest-first value search,
// pop-to-match, aged head pop and occupancy tracking in a single cycle.
module beh_rand_delay_checker_store
  import beh_rand_delay_checker_pkg::*;
#(
  parameter int unsigned BUS_WIDTH = 32,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned MAX_AGE   = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [BUS_WIDTH-1:0]   push_val,
  input  logic                   srch,
  input  logic [BUS_WIDTH-1:0]   srch_val,
  input  ts_t                    ts_now,
  output logic                   hit_c,
  output logic                   hit_skip_c,
  output ts_t                    hit_ts_c,
  output logic                   late_c,
  output logic                   ovf_c,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [BUS_WIDTH-1:0] value;
    ts_t                  ts;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          vent [DEPTH+1];
  logic [DEPTH:0]  vok;
  logic [PW-1:0]   head_q, head_nxt, wr_idx;
  logic [CW-1:0]   count_q, count_nxt;
  logic            wr_en;
  int              hit_idx, drop, vcnt, rem, total;
  ts_t             head_ts;

  // Virtual view: held entries oldest-first, then this cycle's push at age 0.
  always_comb begin : virt_view
    vok  = '0;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      vok[i]  = (CW'(i) < count_q) || ((CW'(i) == count_q) && push);
      vent[i] = (CW'(i) < count_q) ? mem[PW'(head_q + PW'(i))] : {push_val, ts_now};
    end
  end

  // Search, coalescing pop, late check on the surviving head, then occupancy.
  always_comb begin : update
    hit_c    = 1'b0;
    hit_idx  = 0;
    hit_ts_c = '0;
    head_ts  = '0;
    for (int i = int'(DEPTH); i >= 0; i--) begin
      if (srch && vok[i] && (vent[i].value == srch_val)) begin
        hit_c    = 1'b1;
        hit_idx  = i;
        hit_ts_c = vent[i].ts;
      end
    end
    hit_skip_c = hit_c && (hit_idx != 0);
    vcnt       = int'(count_q) + (push ? 1 : 0);
    drop       = hit_c ? hit_idx + 1 : 0;
    rem        = vcnt - drop;
    for (int i = 0; i <= int'(DEPTH); i++) begin
      if (i == drop) head_ts = vent[i].ts;
    end
    late_c    = (rem > 0) && (age(ts_now, head_ts) > TS_W'(MAX_AGE));
    total     = rem - (late_c ? 1 : 0);
    ovf_c     = total > int'(DEPTH);
    count_nxt = ovf_c ? CW'(DEPTH) : CW'(total);
    head_nxt  = head_q + PW'(drop + (late_c ? 1 : 0));
    wr_en     = push && !ovf_c;
    wr_idx    = head_q + PW'(count_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      count_q <= '0;
      empty   <= 1'b1;
    end else begin
      head_q  <= head_nxt;
      count_q <= count_nxt;
      empty   <= (count_nxt == '0);
    end
  end

  // Entry storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= {push_val, ts_now};
  end

  assign count = count_q;

endmodule

// File: rtl/beh_rand_delay_checker.sv
// Per-transition observer for a beh_rand_delay instance: timestamps input
// changes and checks each output change for order, timing, loss and overflow.
module beh_rand_delay_checker
  import beh_rand_delay_checker_pkg::*;
#(
  parameter int unsigned BUS_WIDTH   = 32,
  parameter int unsigned MIN_DELAY   = 0,
  parameter int unsigned MAX_DELAY   = 20,
  parameter int unsigned FIXED_DELAY = 0,
  parameter int unsigned DEPTH       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [BUS_WIDTH-1:0]   bus_in,
  input  logic [BUS_WIDTH-1:0]   bus_out,
  output logic [31:0]            in_count,
  output logic [31:0]            out_count,
  output logic [31:0]            match_count,
  output logic [$clog2(DEPTH):0] pending,
  output logic                   idle,
  output logic                   err_early,
  output logic                   err_late,
  output logic                   err_unknown,
  output logic                   err_skip,
  output logic                   err_overflow
);

  localparam bit FIXED = (FIXED_DELAY != 0);

  ts_t                  ts_q;
  logic                 base_vld;
  logic [BUS_WIDTH-1:0] base_in, base_out;
  logic                 in_ev_c, out_ev_c, early_c;
  logic                 hit_c, hit_skip_c, late_c, ovf_c;
  ts_t                  hit_ts_c, hit_age_c;

  always_comb begin : events
    in_ev_c   = base_vld && en && (bus_in != base_in);
    out_ev_c  = base_vld && en && (bus_out != base_out);
    hit_age_c = age(ts_q, hit_ts_c);
    early_c   = hit_c && ((hit_age_c < TS_W'(MIN_DELAY)) ||
                          (FIXED && (hit_age_c != TS_W'(MAX_DELAY))));
  end

  beh_rand_delay_checker_store #(
    .BUS_WIDTH (BUS_WIDTH),
    .DEPTH     (DEPTH),
    .MAX_AGE   (MAX_DELAY)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .push       (in_ev_c),
    .push_val   (bus_in),
    .srch       (out_ev_c),
    .srch_val   (bus_out),
    .ts_now     (ts_q),
    .hit_c      (hit_c),
    .hit_skip_c (hit_skip_c),
    .hit_ts_c   (hit_ts_c),
    .late_c     (late_c),
    .ovf_c      (ovf_c),
    .count      (pending),
    .empty      (idle)
  );

  // Baselines, timestamp, counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q         <= '0;
      base_vld     <= 1'b0;
      base_in      <= '0;
      base_out     <= '0;
      in_count     <= '0;
      out_count    <= '0;
      match_count  <= '0;
      err_early    <= 1'b0;
      err_late     <= 1'b0;
      err_unknown  <= 1'b0;
      err_skip     <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      ts_q     <= ts_q + TS_W'(1);
      base_vld <= 1'b1;
      base_in  <= bus_in;
      base_out <= bus_out;
      if (in_ev_c)             in_count    <= in_count + 32'd1;
      if (out_ev_c)            out_count   <= out_count + 32'd1;
      if (hit_c && !early_c)   match_count <= match_count + 32'd1;
      if (early_c)             err_early    <= 1'b1;
      if (late_c)              err_late     <= 1'b1;
      if (out_ev_c && !hit_c)  err_unknown  <= 1'b1;
      if (FIXED && hit_skip_c) err_skip     <= 1'b1;
      if (ovf_c)               err_overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_beh_rand_delay_checker.sv
// Directed bench: exact-delay stream plus skip on a fixed-delay instance, and a
// table of window/late/skip/overflow/unknown/drain/reset vectors on a windowed one.
module tb_beh_rand_delay_checker;

  typedef struct packed {
    logic [31:0] in_c;
    logic [31:0] out_c;
    logic [31:0] match_c;
    logic [5:0]  pend;
    logic        idle;
    logic [4:0]  err;   // early, late, unknown, skip, overflow
  } obs_t;

  typedef struct packed {
    logic        rst;
    logic        en;
    logic [31:0] din;
    logic [31:0] dout;
    logic [7:0]  hold;
    obs_t        exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, en_a, rst_b, en_b;
  logic [31:0] din_a, dout_a, din_b, dout_b;
  logic [31:0] inc_a, outc_a, mc_a, inc_b, outc_b, mc_b;
  logic [5:0]  pend_a;
  logic [2:0]  pend_b;
  logic        idle_a, ee_a, el_a, eu_a, es_a, eo_a;
  logic        idle_b, ee_b, el_b, eu_b, es_b, eo_b;
  obs_t        obs_a, obs_b;

  beh_rand_delay_checker #(
    .BUS_WIDTH(32), .MIN_DELAY(0), .MAX_DELAY(10), .FIXED_DELAY(1), .DEPTH(32)
  ) u_fix (
    .clk(clk), .rst(rst_a), .en(en_a), .bus_in(din_a), .bus_out(dout_a),
    .in_count(inc_a), .out_count(outc_a), .match_count(mc_a), .pending(pend_a),
    .idle(idle_a), .err_early(ee_a), .err_late(el_a), .err_unknown(eu_a),
    .err_skip(es_a), .err_overflow(eo_a)
  );

  beh_rand_delay_checker #(
    .BUS_WIDTH(32), .MIN_DELAY(5), .MAX_DELAY(15), .FIXED_DELAY(0), .DEPTH(4)
  ) u_win (
    .clk(clk), .rst(rst_b), .en(en_b), .bus_in(din_b), .bus_out(dout_b),
    .in_count(inc_b), .out_count(outc_b), .match_count(mc_b), .pending(pend_b),
    .idle(idle_b), .err_early(ee_b), .err_late(el_b), .err_unknown(eu_b),
    .err_skip(es_b), .err_overflow(eo_b)
  );

  assign obs_a = {inc_a, outc_a, mc_a, pend_a, idle_a, ee_a, el_a, eu_a, es_a, eo_a};
  assign obs_b = {inc_b, outc_b, mc_b, {3'b000, pend_b}, idle_b, ee_b, el_b, eu_b, es_b, eo_b};

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t tv [26];

  function automatic obs_t ex(input int ic, input int oc, input int mc, input int p,
                              input logic [4:0] er);
    obs_t o;
    o.in_c    = 32'(ic);
    o.out_c   = 32'(oc);
    o.match_c = 32'(mc);
    o.pend    = 6'(p);
    o.idle    = (p == 0);
    o.err     = er;
    return o;
  endfunction

  function automatic vec_t vv(input logic r, input logic e, input logic [31:0] di,
                              input logic [31:0] dq, input int h, input obs_t x);
    vec_t v;
    v.rst  = r;
    v.en   = e;
    v.din  = di;
    v.dout = dq;
    v.hold = 8'(h);
    v.exp  = x;
    return v;
  endfunction

  // Distinct, nonzero, always-changing stream values for c = 1..100.
  function automatic logic [31:0] val(input int c);
    int k;
    k = (c > 100) ? 100 : c;
    if (k <= 0) return 32'h0;
    return 32'(k) * 32'h9E37_79B1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input int idx, input bit sel, input obs_t exp);
    obs_t act;
    act = sel ? obs_b : obs_a;
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got in=%0d out=%0d match=%0d pend=%0d idle=%0b err(ELUSO)=%05b; want in=%0d out=%0d match=%0d pend=%0d idle=%0b err(ELUSO)=%05b",
               tag, idx, act.in_c, act.out_c, act.match_c, act.pend, act.idle, act.err,
               exp.in_c, exp.out_c, exp.match_c, exp.pend, exp.idle, exp.err);
    end
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b1; din_a = '0; dout_a = '0;
    rst_b = 1'b1; en_b = 1'b1; din_b = '0; dout_b = '0;

    //           rst   en    din         dout        hold  in  out mc  pend err
    tv[0]  = vv(1'b1, 1'b1, 32'h00,     32'h00,     2,  ex(0,  0,  0, 0, 5'b00000));
    tv[1]  = vv(1'b0, 1'b1, 32'h00,     32'h00,     2,  ex(0,  0,  0, 0, 5'b00000));
    tv[2]  = vv(1'b0, 1'b1, 32'hA5,     32'h00,     3,  ex(1,  0,  0, 1, 5'b00000));
    tv[3]  = vv(1'b0, 1'b1, 32'hA5,     32'hA5,     1,  ex(1,  1,  0, 0, 5'b10000));
    tv[4]  = vv(1'b1, 1'b1, 32'hA5,     32'hA5,     1,  ex(0,  0,  0, 0, 5'b00000));
    tv[5]  = vv(1'b0, 1'b1, 32'hA5,     32'hA5,     2,  ex(0,  0,  0, 0, 5'b00000));
    tv[6]  = vv(1'b0, 1'b1, 32'h11,     32'hA5,     7,  ex(1,  0,  0, 1, 5'b00000));
    tv[7]  = vv(1'b0, 1'b1, 32'h11,     32'h11,     1,  ex(1,  1,  1, 0, 5'b00000));
    tv[8]  = vv(1'b0, 1'b1, 32'h3C,     32'h11,     16, ex(2,  1,  1, 1, 5'b00000));
    tv[9]  = vv(1'b0, 1'b1, 32'h3C,     32'h11,     1,  ex(2,  1,  1, 0, 5'b01000));
    tv[10] = vv(1'b0, 1'b1, 32'h01,     32'h11,     1,  ex(3,  1,  1, 1, 5'b01000));
    tv[11] = vv(1'b0, 1'b1, 32'h02,     32'h11,     1,  ex(4,  1,  1, 2, 5'b01000));
    tv[12] = vv(1'b0, 1'b1, 32'h03,     32'h11,     6,  ex(5,  1,  1, 3, 5'b01000));
    tv[13] = vv(1'b0, 1'b1, 32'h03,     32'h03,     1,  ex(5,  2,  2, 0, 5'b01000));
    tv[14] = vv(1'b0, 1'b1, 32'h21,     32'h03,     1,  ex(6,  2,  2, 1, 5'b01000));
    tv[15] = vv(1'b0, 1'b1, 32'h22,     32'h03,     1,  ex(7,  2,  2, 2, 5'b01000));
    tv[16] = vv(1'b0, 1'b1, 32'h23,     32'h03,     1,  ex(8,  2,  2, 3, 5'b01000));
    tv[17] = vv(1'b0, 1'b1, 32'h24,     32'h03,     1,  ex(9,  2,  2, 4, 5'b01000));
    tv[18] = vv(1'b0, 1'b1, 32'h25,     32'h03,     1,  ex(10, 2,  2, 4, 5'b01001));
    tv[19] = vv(1'b0, 1'b1, 32'h25,     32'h77,     1,  ex(10, 3,  2, 4, 5'b01101));
    tv[20] = vv(1'b0, 1'b0, 32'h30,     32'h21,     1,  ex(10, 3,  2, 4, 5'b01101));
    tv[21] = vv(1'b0, 1'b0, 32'h30,     32'h21,     12, ex(10, 3,  2, 1, 5'b01101));
    tv[22] = vv(1'b0, 1'b0, 32'h30,     32'h21,     1,  ex(10, 3,  2, 0, 5'b01101));
    tv[23] = vv(1'b1, 1'b0, 32'h30,     32'h21,     1,  ex(0,  0,  0, 0, 5'b00000));
    tv[24] = vv(1'b0, 1'b1, 32'h30,     32'h21,     2,  ex(0,  0,  0, 0, 5'b00000));
    tv[25] = vv(1'b0, 1'b1, 32'h31,     32'h21,     1,  ex(1,  0,  0, 1, 5'b00000));

    @(negedge clk);

    // Fixed-delay instance: reset, baseline, 100-transition exact-delay stream.
    tick(2);
    check("fix_reset", 0, 1'b0, ex(0, 0, 0, 0, 5'b00000));
    rst_a = 1'b0;
    tick(2);
    check("fix_base", 0, 1'b0, ex(0, 0, 0, 0, 5'b00000));
    for (int c = 1; c <= 115; c++) begin
      din_a  = val(c);
      dout_a = val(c - 10);
      tick(1);
      if (c == 50)  check("fix_stream", c, 1'b0, ex(50, 40, 40, 10, 5'b00000));
      if (c == 115) check("fix_stream", c, 1'b0, ex(100, 100, 100, 0, 5'b00000));
    end

    // Fixed-delay skip: three inputs, only the last one emerges.
    din_a = 32'h1; tick(1);
    din_a = 32'h2; tick(1);
    din_a = 32'h3; tick(6);
    check("fix_skip_pre", 0, 1'b0, ex(103, 100, 100, 3, 5'b00000));
    dout_a = 32'h3; tick(1);
    check("fix_skip", 0, 1'b0, ex(103, 101, 100, 0, 5'b10010));

    // Windowed instance: table-driven vectors.
    for (int i = 0; i < 26; i++) begin
      rst_b  = tv[i].rst;
      en_b   = tv[i].en;
      din_b  = tv[i].din;
      dout_b = tv[i].dout;
      tick(int'(tv[i].hold));
      check("win", i, 1'b1, tv[i].exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
